adxl345_stream_responder: RTL
=============================

ADXL345_STREAM_RESPONDER -- requirements
Module: adxl345_stream_responder

Interface
REQ-001 Parameter DEVICE_ADDR, default 7'h53: 7-bit device address this responder answers to.
REQ-002 Parameter DEVID_VALUE, default 8'hE5: reset and constant value of register 0x00.
REQ-003 CLK  in  1: single clock; all logic on posedge CLK.
REQ-004 RESETN  in  1: reset, asynchronous and active-low.
REQ-005 S_AXIS_TDATA  in  8: command byte.
REQ-006 S_AXIS_TKEEP  in  1: byte valid; ignored.
REQ-007 S_AXIS_TUSER  in  8: bits [7:1] are the target address; bit [0] is 1 for a read and 0 for a write.
REQ-008 S_AXIS_TVALID, S_AXIS_TLAST  in  1 each: command beat valid; last beat of the packet.
REQ-009 S_AXIS_TREADY  out  1: command accept.
REQ-010 M_AXIS_TDATA  out  8: response byte.
REQ-011 M_AXIS_TKEEP  out  1: constant 1.
REQ-012 M_AXIS_TUSER  out  8: {DEVICE_ADDR, 1'b1}.
REQ-013 M_AXIS_TVALID, M_AXIS_TLAST  out  1 each: response valid; last response byte.
REQ-014 M_AXIS_TREADY  in  1: response accept.
REQ-015 SAMPLE_VALID  in  1: one-cycle strobe, new sample present.
REQ-016 SAMPLE_X, SAMPLE_Y, SAMPLE_Z  in  16 each: signed sample values.

Function
REQ-017 The block SHALL hold a 64x8 register file (0x00-0x3F) and a 6-bit pointer PTR.
REQ-018 The FSM SHALL use the states IDLE, WR_DATA, DROP and RD_SEND.
REQ-019 S_AXIS_TREADY SHALL be 1 in IDLE, WR_DATA and DROP, and 0 in RD_SEND.
REQ-020 In IDLE, an address mismatch (TUSER[7:1] != DEVICE_ADDR) SHALL move the FSM to DROP if TLAST=0, else keep it in IDLE; the beat has no effect.
REQ-021 In IDLE, a matched write beat SHALL load PTR <= TDATA[5:0]; the FSM goes to WR_DATA if TLAST=0, else stays in IDLE (pointer-only packet).
REQ-022 In IDLE, a matched read beat with TLAST=1 SHALL load CNT <= TDATA (0 means 256) and go to RD_SEND.
- A matched read beat with TLAST=0 goes to DROP, and no response is sent.
REQ-023 In WR_DATA, each accepted beat SHALL write reg[PTR] if PTR is writable, then PTR <= PTR+1; TLAST returns the FSM to IDLE.
REQ-024 Writable addresses SHALL be 0x1D-0x2A, 0x2C-0x2F, 0x31 and 0x38.
- Writes to any other address are silently discarded.
- PTR still increments.
REQ-025 DROP SHALL consume beats until TLAST, then return to IDLE with no state change.
REQ-026 In RD_SEND, M_AXIS_TVALID=1 and M_AXIS_TDATA=reg[PTR]; M_AXIS_TLAST=1 when CNT==1.
REQ-027 In RD_SEND, on each handshake PTR <= PTR+1 and CNT <= CNT-1; the handshake with TLAST returns the FSM to IDLE.
REQ-028 M_AXIS_TDATA and M_AXIS_TLAST SHALL be driven from registers.
- They stay stable while TVALID=1 and TREADY=0.
- The first byte is valid one cycle after the read beat is accepted.
- Consecutive bytes stream at 1 per cycle while TREADY=1.
REQ-029 PTR SHALL wrap from 0x3F to 0x00 in both the write and read paths.
REQ-030 A sample SHALL be stored little-endian in 0x32-0x37 (X low, X high, Y low, Y high, Z low, Z high).
- Outside RD_SEND, it is stored on the cycle after SAMPLE_VALID.
- In RD_SEND, the latest sample is held pending and stored on the cycle RD_SEND exits; a newer sample overwrites the pending one.
REQ-031 INT_SOURCE (0x30) bit 7 SHALL be set when a sample is stored.
- It is cleared by a read handshake of address 0x32-0x37.
- If set and clear occur on the same cycle, set wins.
- Bits [6:0] read as 0.
REQ-032 Register 0x00 SHALL always read DEVID_VALUE.

Reset
REQ-033 On RESETN=0, asynchronously, the block SHALL:
- set the FSM to IDLE and PTR=0 and CNT=0;
- set all registers to 0x00 except 0x00=DEVID_VALUE and 0x2C=0x0A;
- clear the pending sample;
- drive M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0 and S_AXIS_TREADY=0.
REQ-034 S_AXIS_TREADY SHALL rise on the first clock after RESETN deasserts.
REQ-035 A reset asserted mid-packet SHALL abort the packet with no further output beats.

Verification
REQ-036 Reset, then read packet {TUSER=0xA7, TDATA=1, TLAST} -> one byte 0xE5 with TLAST.
REQ-037 Write {0x2D, 0x08} then {0x2D} and read CNT=1 -> 0x08.
REQ-038 Write {0x00, 0x55} -> reg 0x00 still reads 0xE5.
REQ-039 SAMPLE X=0x1234, Y=0xFFFE, Z=0x0100; set PTR=0x32; read CNT=6 -> 34 12 FE FF 00 01, TLAST on the 6th byte, INT_SOURCE read afterwards = 0x00.
REQ-040 Set PTR=0x3E and read CNT=3 with TREADY toggled 1-0-1 -> reg 0x3E, 0x3F, 0xE5 in order, data held during stalls.
REQ-041 Write packet to TUSER=0x20 (address mismatch), 3 beats -> all accepted, register file unchanged, no M_AXIS output.

Source files
------------

// File: rtl/adxl345_stream_responder_if.sv
// Byte-wide AXI-Stream style channel used for both the command and response
// paths of the accelerometer register responder.
interface adxl345_stream_responder_if;
  logic [7:0] TDATA;
  logic       TKEEP;
  logic [7:0] TUSER;
  logic       TVALID;
  logic       TLAST;
  logic       TREADY;

  modport master (output TDATA, TKEEP, TUSER, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TKEEP, TUSER, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/adxl345_stream_responder.sv
// ADXL345-like register responder: command packets set the pointer, write
// registers or request a read burst; sample strobes update the data registers.
module adxl345_stream_responder #(
  parameter logic [6:0] DEVICE_ADDR = 7'h53,
  parameter logic [7:0] DEVID_VALUE = 8'hE5
) (
  input  logic                              CLK,
  input  logic                              RESETN,
  adxl345_stream_responder_if.slave         s_axis,
  adxl345_stream_responder_if.master        m_axis,
  input  logic                              SAMPLE_VALID,
  input  logic [15:0]                       SAMPLE_X,
  input  logic [15:0]                       SAMPLE_Y,
  input  logic [15:0]                       SAMPLE_Z
);
  // state   | meaning
  // IDLE    | waiting for the first beat of a packet
  // WR_DATA | write packet: each beat writes reg[PTR], PTR advances
  // DROP    | foreign or malformed packet: swallow beats until TLAST
  // RD_SEND | streaming CNT bytes starting at reg[PTR]
  typedef enum logic [1:0] {IDLE, WR_DATA, DROP, RD_SEND} state_t;

  state_t      state, state_nxt;
  logic [7:0]  regs [64];
  logic [5:0]  ptr;
  logic [7:0]  cnt;
  logic        ready_en;
  logic        int_flag;
  logic        pend;
  logic [47:0] pend_data;
  logic        m_valid, m_last;
  logic [7:0]  m_data;

  logic        s_fire, m_fire, addr_match, is_read, rd_exit, store;
  logic [5:0]  ptr_inc;
  logic [7:0]  rd_at_ptr, rd_at_inc;
  logic        unused_tkeep;

  function automatic logic writable(input logic [5:0] a);
    return (a >= 6'h1D && a <= 6'h2A) || (a >= 6'h2C && a <= 6'h2F) ||
           a == 6'h31 || a == 6'h38;
  endfunction

  // 0x00 and 0x30 are synthesised on read rather than held in the array
  function automatic logic [7:0] reg_rd(input logic [5:0] a);
    if (a == 6'h00)      return DEVID_VALUE;
    else if (a == 6'h30) return {int_flag, 7'b0};
    else                 return regs[a];
  endfunction

  assign unused_tkeep = s_axis.TKEEP;

  assign s_fire     = s_axis.TVALID & s_axis.TREADY;
  assign m_fire     = m_valid & m_axis.TREADY;
  assign addr_match = (s_axis.TUSER[7:1] == DEVICE_ADDR);
  assign is_read    = s_axis.TUSER[0];
  assign rd_exit    = (state == RD_SEND) && m_fire && m_last;
  assign store      = pend && ((state != RD_SEND) || rd_exit);
  assign ptr_inc    = ptr + 6'd1;
  assign rd_at_ptr  = reg_rd(ptr);
  assign rd_at_inc  = reg_rd(ptr_inc);

  assign s_axis.TREADY = ready_en && (state != RD_SEND);
  assign m_axis.TVALID = m_valid;
  assign m_axis.TDATA  = m_data;
  assign m_axis.TLAST  = m_last;
  assign m_axis.TKEEP  = 1'b1;
  assign m_axis.TUSER  = {DEVICE_ADDR, 1'b1};

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (s_fire) begin
          if (!addr_match)  state_nxt = s_axis.TLAST ? IDLE    : DROP;
          else if (is_read) state_nxt = s_axis.TLAST ? RD_SEND : DROP;
          else              state_nxt = s_axis.TLAST ? IDLE    : WR_DATA;
        end
      end
      WR_DATA, DROP: if (s_fire && s_axis.TLAST) state_nxt = IDLE;
      RD_SEND:       if (rd_exit) state_nxt = IDLE;
      default:       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ptr       <= '0;
      cnt       <= '0;
      ready_en  <= 1'b0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
      int_flag  <= 1'b0;
      pend      <= 1'b0;
      pend_data <= '0;
    end else begin
      ready_en <= 1'b1;
      if (state == IDLE && s_fire && addr_match) begin
        if (!is_read) begin
          ptr <= s_axis.TDATA[5:0];
        end else if (s_axis.TLAST) begin
          cnt     <= s_axis.TDATA;
          m_valid <= 1'b1;
          m_data  <= rd_at_ptr;
          m_last  <= (s_axis.TDATA == 8'd1);
        end
      end
      if (state == WR_DATA && s_fire) ptr <= ptr_inc;
      // response byte for the next beat is prefetched on each handshake
      if (state == RD_SEND && m_fire) begin
        ptr <= ptr_inc;
        cnt <= cnt - 8'd1;
        if (m_last) begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end else begin
          m_data <= rd_at_inc;
          m_last <= (cnt == 8'd2);
        end
      end
      if (SAMPLE_VALID) begin
        pend      <= 1'b1;
        pend_data <= {SAMPLE_Z, SAMPLE_Y, SAMPLE_X};
      end else if (store) begin
        pend <= 1'b0;
      end
      if (store)
        int_flag <= 1'b1;
      else if (state == RD_SEND && m_fire && ptr >= 6'h32 && ptr <= 6'h37)
        int_flag <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < 64; i++) regs[i[5:0]] <= 8'h00;
      regs[6'h00] <= DEVID_VALUE;
      regs[6'h2C] <= 8'h0A;
    end else begin
      if (state == WR_DATA && s_fire && writable(ptr)) regs[ptr] <= s_axis.TDATA;
      if (store) begin
        regs[6'h32] <= pend_data[7:0];
        regs[6'h33] <= pend_data[15:8];
        regs[6'h34] <= pend_data[23:16];
        regs[6'h35] <= pend_data[31:24];
        regs[6'h36] <= pend_data[39:32];
        regs[6'h37] <= pend_data[47:40];
      end
    end
  end
endmodule
